// File: rtl/pa_clic_sel_arb.sv
`default_nettype none
// ============================================================================
// Module   : pa_clic_sel_arb
// Purpose  : Two-stage CLIC arbiter that picks the highest-priority eligible
//            interrupt (lowest ID on ties) and presents it on a valid/ack port.
// Revision : 1.0 - initial release
// ============================================================================
module pa_clic_sel_arb #(
  parameter int WIDTH = 6,
  parameter int NUM   = 32,
  parameter int ID_W  = 5
) (
  input  logic                      forever_cpuclk,
  input  logic                      cpurst_b,
  input  logic [(NUM<<WIDTH)-1:0]   expand_in_vec,
  input  logic [NUM-1:0]            int_pend_vec,
  input  logic [WIDTH-1:0]          int_thresh,
  input  logic                      arb_flush,
  input  logic                      core_int_ack,
  output logic                      clic_int_vld,
  output logic [ID_W-1:0]           clic_int_id,
  output logic [WIDTH-1:0]          clic_int_prio
);

  localparam int EXP_WIDTH = 1 << WIDTH;

  logic                 r_s1_vld;
  logic [WIDTH-1:0]     r_s1_prio;
  logic [NUM-1:0]       r_s1_cand;
  logic                 r_int_vld;
  logic [ID_W-1:0]      r_int_id;
  logic [WIDTH-1:0]     r_int_prio;

  logic [EXP_WIDTH-1:0] w_occ;
  logic [EXP_WIDTH-1:0] w_occ_elig;
  logic [WIDTH-1:0]     w_s1_prio;
  logic                 w_s1_any;
  logic [NUM-1:0]       w_match;
  logic                 w_s2_hit;
  logic [ID_W-1:0]      w_s2_id;
  logic                 w_ack_kill;
  logic                 w_out_load;

  // Stage 1: merge the one-hot priorities of every pending source.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < NUM; i++) begin
      if (int_pend_vec[i]) begin
        w_occ = w_occ | expand_in_vec[EXP_WIDTH*i +: EXP_WIDTH];
      end
    end
  end

  // Only priorities strictly above the threshold survive; bit 0 never does.
  genvar b;
  generate
    for (b = 0; b < EXP_WIDTH; b++) begin : g_elig
      assign w_occ_elig[b] = w_occ[b] & (WIDTH'(b) > int_thresh);
    end
  endgenerate

  always_comb begin
    w_s1_prio = '0;
    for (int k = 0; k < EXP_WIDTH; k++) begin
      if (w_occ_elig[k]) begin
        w_s1_prio = WIDTH'(k);
      end
    end
  end

  assign w_s1_any = |w_occ_elig;

  // Stage 2: re-qualify candidates against live pending/priority so a source
  // that dropped or changed priority since stage 1 cannot win.
  genvar i;
  generate
    for (i = 0; i < NUM; i++) begin : g_match
      logic [EXP_WIDTH-1:0] w_slice;
      assign w_slice    = expand_in_vec[EXP_WIDTH*i +: EXP_WIDTH];
      assign w_match[i] = r_s1_cand[i] & w_slice[r_s1_prio] & int_pend_vec[i];
    end
  endgenerate

  always_comb begin
    w_s2_id = '0;
    for (int n = NUM - 1; n >= 0; n--) begin
      if (w_match[n]) begin
        w_s2_id = ID_W'(n);
      end
    end
  end

  assign w_s2_hit   = r_s1_vld & (|w_match);
  assign w_ack_kill = core_int_ack & r_int_vld;
  assign w_out_load = w_s2_hit & (~r_int_vld | core_int_ack) & ~arb_flush & ~w_ack_kill;

  // An ack also empties stage 1 so the core has time to clear the pending bit.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_s1_vld  <= 1'b0;
      r_s1_prio <= '0;
      r_s1_cand <= '0;
    end else begin
      r_s1_vld  <= w_s1_any & ~arb_flush & ~w_ack_kill;
      r_s1_prio <= w_s1_prio;
      r_s1_cand <= int_pend_vec;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_int_vld  <= 1'b0;
      r_int_id   <= '0;
      r_int_prio <= '0;
    end else if (w_ack_kill) begin
      r_int_vld  <= 1'b0;
    end else if (w_out_load) begin
      r_int_vld  <= 1'b1;
      r_int_id   <= w_s2_id;
      r_int_prio <= r_s1_prio;
    end
  end

  assign clic_int_vld  = r_int_vld;
  assign clic_int_id   = r_int_id;
  assign clic_int_prio = r_int_prio;

endmodule
`default_nettype wire

// File: tb/tb_pa_clic_sel_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pa_clic_sel_arb
// Purpose  : Directed and random bench for pa_clic_sel_arb against a
//            per-source priority model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pa_clic_sel_arb;

  localparam int WIDTH     = 6;
  localparam int NUM       = 32;
  localparam int ID_W      = 5;
  localparam int EXP_WIDTH = 1 << WIDTH;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [EXP_WIDTH*NUM-1:0]  exp_vec;
  logic [NUM-1:0]            pend;
  logic [WIDTH-1:0]          thresh;
  logic                      flush;
  logic                      ack;
  logic                      vld;
  logic [ID_W-1:0]           id;
  logic [WIDTH-1:0]          prio;

  int prio_q [NUM];

  // Reference state: the candidate snapshot and the presented interrupt.
  bit             m_s1_vld;
  int             m_s1_prio;
  bit [NUM-1:0]   m_s1_cand;
  bit             m_vld;
  int             m_id;
  int             m_prio;

  int errors = 0;
  int checks = 0;

  pa_clic_sel_arb #(.WIDTH(WIDTH), .NUM(NUM), .ID_W(ID_W)) u_dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .expand_in_vec  (exp_vec),
    .int_pend_vec   (pend),
    .int_thresh     (thresh),
    .arb_flush      (flush),
    .core_int_ack   (ack),
    .clic_int_vld   (vld),
    .clic_int_id    (id),
    .clic_int_prio  (prio)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic set_prio(input int src, input int p);
    prio_q[src] = p;
    exp_vec[EXP_WIDTH*src +: EXP_WIDTH] = '0;
    exp_vec[EXP_WIDTH*src + p] = 1'b1;
  endtask

  task automatic model_reset();
    m_s1_vld  = 0;
    m_s1_prio = 0;
    m_s1_cand = '0;
    m_vld     = 0;
    m_id      = 0;
    m_prio    = 0;
  endtask

  // Advance the reference by one clock using the inputs held across the edge.
  task automatic model_edge();
    bit kill, hit, load;
    int win, best;
    kill = ack && m_vld;
    hit  = 0;
    win  = 0;
    if (m_s1_vld) begin
      for (int s = NUM - 1; s >= 0; s--) begin
        if (m_s1_cand[s] && pend[s] && prio_q[s] == m_s1_prio) begin
          hit = 1;
          win = s;
        end
      end
    end
    load = hit && (!m_vld || ack) && !flush && !kill;
    if (kill) begin
      m_vld = 0;
    end else if (load) begin
      m_vld  = 1;
      m_id   = win;
      m_prio = m_s1_prio;
    end
    best = -1;
    for (int s = 0; s < NUM; s++) begin
      if (pend[s] && prio_q[s] > int'(thresh) && prio_q[s] > best) best = prio_q[s];
    end
    m_s1_vld  = (best >= 0) && !flush && !kill;
    m_s1_prio = (best >= 0) ? best : 0;
    m_s1_cand = pend;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check("vld",  32'(vld),  32'(m_vld));
      check("id",   32'(id),   32'(m_id));
      check("prio", 32'(prio), 32'(m_prio));
    end
  endtask

  task automatic clear_all();
    pend   = '0;
    flush  = 1'b0;
    ack    = 1'b0;
    thresh = '0;
    for (int k = 0; k < 4 && m_vld; k++) begin
      ack = 1'b1;
      step(1);
      ack = 1'b0;
    end
    step(3);
  endtask

  initial begin
    rst_n   = 1'b0;
    pend    = '0;
    thresh  = '0;
    flush   = 1'b0;
    ack     = 1'b0;
    exp_vec = '0;
    for (int s = 0; s < NUM; s++) set_prio(s, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_vld",  32'(vld),  0);
    check("reset_id",   32'(id),   0);
    check("reset_prio", 32'(prio), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);

    // Single source, latency and hold.
    set_prio(5, 3);
    pend[5] = 1'b1;
    step(1);
    check("single_lat_vld", 32'(vld), 0);
    step(1);
    check("single_vld",  32'(vld),  1);
    check("single_id",   32'(id),   5);
    check("single_prio", 32'(prio), 3);
    step(10);
    check("hold_id",   32'(id),   5);
    check("hold_prio", 32'(prio), 3);
    clear_all();

    // Priority and tie-break, then re-present after ack.
    set_prio(2, 9);
    set_prio(17, 12);
    set_prio(20, 12);
    pend[2] = 1'b1; pend[17] = 1'b1; pend[20] = 1'b1;
    step(2);
    check("tie_id",   32'(id),   17);
    check("tie_prio", 32'(prio), 12);
    ack = 1'b1; pend[17] = 1'b0;
    step(1);
    ack = 1'b0;
    check("ack_clr_vld", 32'(vld), 0);
    step(1);
    check("ack_gap_vld", 32'(vld), 0);
    step(1);
    check("next_vld",  32'(vld),  1);
    check("next_id",   32'(id),   20);
    check("next_prio", 32'(prio), 12);
    clear_all();

    // Threshold boundary.
    set_prio(4, 5);
    pend[4] = 1'b1;
    thresh  = 6'd5;
    step(5);
    check("thresh_eq_vld", 32'(vld), 0);
    thresh = 6'd4;
    step(1);
    check("thresh_lat_vld", 32'(vld), 0);
    step(1);
    check("thresh_vld", 32'(vld), 1);
    check("thresh_id",  32'(id),  4);
    clear_all();

    // Flush on the stage-1 capture edge delays the load by one cycle.
    set_prio(9, 6);
    pend[9] = 1'b1;
    flush   = 1'b1;
    step(1);
    flush = 1'b0;
    step(1);
    check("flush_nominal_vld", 32'(vld), 0);
    step(1);
    check("flush_late_vld", 32'(vld), 1);
    check("flush_id",       32'(id),  9);
    clear_all();

    // Stale candidate: pending drops between the two edges.
    pend[9] = 1'b1;
    step(1);
    pend[9] = 1'b0;
    step(3);
    check("stale_vld", 32'(vld), 0);
    clear_all();

    // Ack and flush together.
    set_prio(1, 7);
    pend[1] = 1'b1;
    step(2);
    check("coll_pre_id", 32'(id), 1);
    ack = 1'b1; flush = 1'b1;
    step(1);
    ack = 1'b0; flush = 1'b0;
    check("coll_low1", 32'(vld), 0);
    step(1);
    check("coll_low2", 32'(vld), 0);
    step(1);
    check("coll_vld", 32'(vld), 1);
    check("coll_id",  32'(id),  1);
    clear_all();

    // Threshold at all-ones masks even the top priority.
    set_prio(3, 63);
    pend[3] = 1'b1;
    thresh  = 6'd63;
    step(4);
    check("thresh_max_vld", 32'(vld), 0);
    clear_all();

    // Asynchronous reset mid-operation.
    set_prio(7, 10);
    pend[7] = 1'b1;
    step(2);
    check("pre_rst_id", 32'(id), 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_vld",  32'(vld),  0);
    check("async_rst_id",   32'(id),   0);
    check("async_rst_prio", 32'(prio), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check("post_rst_vld", 32'(vld), 0);
    step(1);
    check("post_rst_id", 32'(id), 7);
    clear_all();

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(3, 0) == 0) set_prio($urandom_range(NUM - 1, 0), $urandom_range(EXP_WIDTH - 1, 0));
      if ($urandom_range(4, 0) == 0) pend = $urandom & $urandom & $urandom;
      else if ($urandom_range(2, 0) == 0) pend[$urandom_range(NUM - 1, 0)] = 1'(~pend[$urandom_range(NUM - 1, 0)]);
      thresh = ($urandom_range(15, 0) == 0) ? WIDTH'($urandom_range(EXP_WIDTH - 1, 0))
                                            : WIDTH'($urandom_range(8, 0));
      flush  = ($urandom_range(19, 0) == 0);
      ack    = ($urandom_range(2, 0) == 0);
      step(1);
    end
    flush = 1'b0;
    ack   = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pa_clic_sel_arb.md
Name: pa_clic_sel_arb

Overview:
- Arbitration stage directly downstream of the CLIC priority expander.
- Consumes each interrupt's one-hot expanded priority vector plus its pending/enable qualification.
- Selects the highest-priority eligible interrupt (lowest ID on ties) through a 2-stage registered pipeline.
- Presents the winner to the core on a valid/ack handshake.

Parameters:
- WIDTH, 6, bit width of an interrupt priority value; expanded vector width EXP_WIDTH = 1<<WIDTH.
- NUM, 32, number of interrupt sources.
- ID_W, 5, width of interrupt ID output; must satisfy 2^ID_W >= NUM.

Ports:
- forever_cpuclk  in  1  block clock.
- cpurst_b  in  1  reset, asynchronous, active-low.
- expand_in_vec  in  EXP_WIDTH*NUM  per-interrupt one-hot priority; slice i = [EXP_WIDTH*i +: EXP_WIDTH].
- int_pend_vec  in  NUM  pending AND enabled per interrupt.
- int_thresh  in  WIDTH  threshold; interrupt eligible only if its priority > int_thresh.
- arb_flush  in  1  kill in-flight pipeline contents (ctl/threshold CSR write).
- core_int_ack  in  1  core accepts presented interrupt.
- clic_int_vld  out  1  winner valid.
- clic_int_id  out  ID_W  winner interrupt index.
- clic_int_prio  out  WIDTH  winner priority.

Behaviour:
- Reset (cpurst_b low, async): s1_vld=0, s1_prio=0, s1_cand=0; clic_int_vld=0, clic_int_id=0, clic_int_prio=0.
- Stage 1 (comb, registered at edge E1):
  - occ = OR over i of (int_pend_vec[i] ? slice_i : 0).
  - Clear occ bits 0..int_thresh.
  - s1_prio <= index of highest set bit of occ.
  - s1_vld <= (occ != 0).
  - s1_cand <= int_pend_vec.
- Stage 2 (comb from S1 regs + live expand_in_vec):
  - match[i] = s1_cand[i] & slice_i[s1_prio] & int_pend_vec[i].
  - s2_hit = s1_vld & |match.
  - s2_id = lowest i with match[i] set.
- Output register load condition (edge E2): s2_hit & (!clic_int_vld | core_int_ack) & !arb_flush & !core_int_ack_kill.
  - Loads clic_int_id <= s2_id, clic_int_prio <= s1_prio, clic_int_vld <= 1.
- Latency: pending presented before edge E1 -> clic_int_vld high after E2 (2 cycles).
- Handshake:
  - While clic_int_vld=1 and core_int_ack=0, id/prio held stable; the pipeline keeps resampling but does not update the output.
  - core_int_ack with clic_int_vld=1: clic_int_vld <= 0 at that edge, s1_vld <= 0 (kill).
  - The acked request is not reloaded that cycle (core_int_ack_kill = core_int_ack & clic_int_vld).
  - Next winner earliest 2 cycles after the ack edge, which gives the core time to clear the pending bit.
  - core_int_ack with clic_int_vld=0: ignored.
- arb_flush: s1_vld <= 0 and the output does not load that cycle. A presented clic_int_vld is NOT dropped by flush; only ack clears it.
- Simultaneous ack + flush: vld clears, s1 cleared, no load.
- Ties: equal priority resolves to the lowest index. No preemption of a presented, unacked interrupt even if a higher priority arrives.
- Stale S1: if the pending bit drops or the priority changes between E1 and E2, match excludes it. If match is empty, nothing loads (no bubble error).
- Priority 0 is never eligible (thresh >= 0 masks bit 0).
- int_thresh = all-ones: nothing eligible, clic_int_vld stays 0 once the current one is acked.
- Only one bit per slice is assumed set (expander guarantees it); multi-hot slices are outside spec.

Test Plan:
- Reset mid-operation: clic_int_vld=1, id=7; assert cpurst_b low asynchronously between edges -> all outputs 0 immediately; pipeline empty after release (no vld for 2 cycles).
- Single source: pend[5]=1, prio 3, thresh 0 -> vld=1, id=5, prio=3 exactly 2 cycles later; hold without ack 10 cycles -> stable.
- Priority/tie: pend[2] prio 9, pend[17] prio 12, pend[20] prio 12 -> id=17, prio=12. Ack and clear pend[17] -> next id=20, prio=12, vld re-asserts 2 cycles after the ack edge.
- Threshold: pend[4] prio 5, thresh 5 -> vld never asserts. Lower thresh to 4 -> vld after 2 cycles with id=4.
- Flush/stale: pend[9] prio 6 raised, arb_flush pulsed on the cycle S1 captures -> no load that cycle; vld appears one cycle later than nominal with id=9. Drop pend[9] between E1 and E2 -> no vld.
- Ack collision: ack and arb_flush in the same cycle with pend[1] still high -> vld low for exactly 2 cycles, then id=1 re-presented.
